// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one external combinational ALU between two requesters, with registered tagged response.
// Optional statistics counters are enabled by defining ALU_SHARE_STATS_EN.
module alu_share_arbiter #(
    parameter int WIDTH = 4,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OPW-1:0]   req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OPW-1:0]   req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [OPW-1:0]   alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_c,
    input  logic             alu_v,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_y,
    output logic [3:0]       rsp_flags
`ifdef ALU_SHARE_STATS_EN
    ,
    output logic [7:0]       grant_cnt0,
    output logic [7:0]       grant_cnt1,
    output logic [7:0]       zero_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q, state_d;
    logic             last_grant_q;
    logic             grant_q;
    logic [OPW-1:0]   op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] rsp_y_q;
    logic [3:0]       rsp_flags_q;
    logic             rsp_id_q;
    logic             win_valid;
    logic             win_id;

    always_comb begin
        state_d    = state_q;
        win_valid  = 1'b0;
        win_id     = last_grant_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        alu_op     = '0;
        alu_a      = '0;
        alu_b      = '0;
        case (state_q)
            IDLE: begin
                // Both valid: alternate away from the previous winner.
                if (req0_valid && req1_valid) begin
                    win_valid = 1'b1;
                    win_id    = ~last_grant_q;
                end else if (req0_valid) begin
                    win_valid = 1'b1;
                    win_id    = 1'b0;
                end else if (req1_valid) begin
                    win_valid = 1'b1;
                    win_id    = 1'b1;
                end
                if (win_valid && rst_n) begin
                    req0_ready = ~win_id;
                    req1_ready = win_id;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                alu_op  = op_q;
                alu_a   = a_q;
                alu_b   = b_q;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            rsp_y_q      <= '0;
            rsp_flags_q  <= '0;
            rsp_id_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && win_valid) begin
                grant_q      <= win_id;
                last_grant_q <= win_id;
                op_q         <= win_id ? req1_op : req0_op;
                a_q          <= win_id ? req1_a  : req0_a;
                b_q          <= win_id ? req1_b  : req0_b;
            end
            if (state_q == EXEC) begin
                rsp_y_q     <= alu_y;
                rsp_flags_q <= {alu_y[WIDTH-1], (alu_y == '0), alu_c, alu_v};
                rsp_id_q    <= grant_q;
            end
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_y     = rsp_y_q;
    assign rsp_flags = rsp_flags_q;
    assign rsp_id    = rsp_id_q;

`ifdef ALU_SHARE_STATS_EN
    logic [7:0] grant_cnt0_q, grant_cnt1_q, zero_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt0_q <= '0;
            grant_cnt1_q <= '0;
            zero_cnt_q   <= '0;
        end else begin
            if (state_q == IDLE && win_valid) begin
                if (win_id) grant_cnt1_q <= grant_cnt1_q + 8'd1;
                else        grant_cnt0_q <= grant_cnt0_q + 8'd1;
            end
            if (state_q == EXEC && alu_y == '0) zero_cnt_q <= zero_cnt_q + 8'd1;
        end
    end

    assign grant_cnt0 = grant_cnt0_q;
    assign grant_cnt1 = grant_cnt1_q;
    assign zero_cnt   = zero_cnt_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: reference ALU model, response scoreboard, fairness/backpressure/reset steps.
module tb_alu_share_arbiter;
    localparam int WIDTH = 4;
    localparam int OPW   = 4;
    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_XOR = 4'd3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req0_valid = 1'b0, req1_valid = 1'b0;
    logic req0_ready, req1_ready;
    logic [OPW-1:0] req0_op = '0, req1_op = '0;
    logic [WIDTH-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [OPW-1:0] alu_op;
    logic [WIDTH-1:0] alu_a, alu_b, alu_y;
    logic alu_c, alu_v;
    logic rsp_valid, rsp_id;
    logic rsp_ready = 1'b0;
    logic [WIDTH-1:0] rsp_y;
    logic [3:0] rsp_flags;
`ifdef ALU_SHARE_STATS_EN
    logic [7:0] grant_cnt0, grant_cnt1, zero_cnt;
`endif

    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y), .alu_c(alu_c), .alu_v(alu_v),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_flags(rsp_flags)
`ifdef ALU_SHARE_STATS_EN
        , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .zero_cnt(zero_cnt)
`endif
    );

    // Reference ALU: returns {c, v, y}.
    function automatic logic [5:0] alu_ref(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] s;
        logic v;
        s = '0;
        v = 1'b0;
        case (op)
            OP_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                v = (a[3] == b[3]) && (s[3] != a[3]);
            end
            OP_SUB: begin
                s = {1'b0, a} + {1'b0, ~b} + 5'd1;
                v = (a[3] != b[3]) && (s[3] != a[3]);
            end
            OP_AND:  s = {1'b0, a & b};
            OP_XOR:  s = {1'b0, a ^ b};
            default: s = {1'b0, a | b};
        endcase
        return {s[4], v, s[3:0]};
    endfunction

    assign {alu_c, alu_v, alu_y} = alu_ref(alu_op, alu_a, alu_b);

    typedef struct packed {
        logic       id;
        logic [3:0] flags;
        logic [3:0] y;
    } exp_t;

    function automatic exp_t model(input logic id, input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [5:0] r;
        exp_t e;
        r = alu_ref(op, a, b);
        e.id = id;
        e.y = r[3:0];
        e.flags = {r[3], (r[3:0] == 4'd0), r[5], r[4]};
        return e;
    endfunction

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_acc = 0;
    logic rsp_valid_prev = 1'b0;
    exp_t sb[$];
    logic grants[$];
    int acc_cyc[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: push at accept, pop at response handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (req0_ready || req1_ready) check("ready_onehot", req0_ready & req1_ready, 0);
            if (req0_valid && req0_ready) begin
                sb.push_back(model(1'b0, req0_op, req0_a, req0_b));
                grants.push_back(1'b0);
                acc_cyc.push_back(cyc);
                last_acc <= cyc;
                $display("accept id=0 op=%0d a=%0h b=%0h cyc=%0d", req0_op, req0_a, req0_b, cyc);
            end
            if (req1_valid && req1_ready) begin
                sb.push_back(model(1'b1, req1_op, req1_a, req1_b));
                grants.push_back(1'b1);
                acc_cyc.push_back(cyc);
                last_acc <= cyc;
                $display("accept id=1 op=%0d a=%0h b=%0h cyc=%0d", req1_op, req1_a, req1_b, cyc);
            end
            if (rsp_valid && !rsp_valid_prev) check("latency", cyc - last_acc, 2);
            if (rsp_valid) check("alu_idle_in_resp", {alu_op, alu_a, alu_b}, 0);
            if (rsp_valid && rsp_ready) begin
                check("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("rsp_id", rsp_id, e.id);
                    check("rsp_y", rsp_y, e.y);
                    check("rsp_flags", rsp_flags, e.flags);
                    $display("response id=%0d y=%0h flags=%b cyc=%0d", rsp_id, rsp_y, rsp_flags, cyc);
                end
            end
        end
        rsp_valid_prev <= rst_n ? rsp_valid : 1'b0;
    end

    task automatic drive(input logic id, input logic v, input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        if (id) begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end
    endtask

    task automatic issue(input logic id, input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        logic found;
        found = 1'b0;
        drive(id, 1'b1, op, a, b);
        for (int i = 0; i < 12 && !found; i++) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) found = 1'b1;
        end
        check("accept_timeout", found, 1);
        @(posedge clk); #1;
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic wait_rsp(output logic [3:0] y, output logic [3:0] f, output logic id);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            @(negedge clk);
            if (rsp_valid) found = 1'b1;
        end
        check("rsp_timeout", found, 1);
        y = rsp_y; f = rsp_flags; id = rsp_id;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] y, f;
        logic id;

        // Reset with a pending request
        rst_n = 1'b0;
        rsp_ready = 1'b1;
        drive(1'b0, 1'b1, OP_ADD, 4'b0011, 4'b1101);
        repeat (3) @(negedge clk);
        check("rst_req0_ready", req0_ready, 0);
        check("rst_req1_ready", req1_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_y", rsp_y, 0);
        check("rst_rsp_flags", rsp_flags, 0);
        check("rst_alu", {alu_op, alu_a, alu_b}, 0);
`ifdef ALU_SHARE_STATS_EN
        check("rst_stats", {grant_cnt0, grant_cnt1, zero_cnt}, 0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("first_idle_ready0", req0_ready, 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        wait_rsp(y, f, id);
        check("single_y", y, 4'b0000);
        check("single_flags", f, 4'b0110);
        check("single_id", id, 0);

        // Fairness after a fresh reset
        @(posedge clk); #1;
        rst_n = 1'b0;
        sb.delete(); grants.delete(); acc_cyc.delete();
        drive(1'b0, 1'b1, OP_SUB, 4'd5, 4'd7);
        drive(1'b1, 1'b1, OP_ADD, 4'd9, 4'd9);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 40 && grants.size() < 4; i++) @(negedge clk);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("fair_count", grants.size(), 4);
        if (grants.size() >= 4) begin
            for (int i = 0; i < 4; i++) check($sformatf("fair_grant%0d", i), grants[i], i % 2);
            for (int i = 1; i < 4; i++) check($sformatf("fair_gap%0d", i), acc_cyc[i] - acc_cyc[i-1], 3);
        end
        repeat (4) @(negedge clk);
        check("fair_drained", sb.size(), 0);

        // Backpressure in RESP
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        issue(1'b1, OP_SUB, 4'd2, 4'd5);
        drive(1'b0, 1'b1, OP_ADD, 4'd4, 4'd4);
        wait_rsp(y, f, id);
        check("bp_first_y", y, 4'b1101);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", rsp_valid, 1);
            check("bp_y", rsp_y, 4'b1101);
            check("bp_flags", rsp_flags, 4'b1000);
            check("bp_no_ready", {req0_ready, req1_ready}, 0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_regrant_ready0", req0_ready, 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        wait_rsp(y, f, id);
        check("neg_y", y, 4'b1000);
        check("neg_flags", f, 4'b1001);
        check("neg_id", id, 0);

        // Small positive result
        issue(1'b1, OP_XOR, 4'b0011, 4'b0010);
        wait_rsp(y, f, id);
        check("pos_y", y, 4'b0001);
        check("pos_flags", f, 4'b0000);
        check("pos_id", id, 1);

        // Reset during EXEC drops the operation
        issue(1'b0, OP_ADD, 4'd1, 4'd1);
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        check("midrst_rsp_valid", rsp_valid, 0);
        check("midrst_alu", {alu_op, alu_a, alu_b}, 0);
`ifdef ALU_SHARE_STATS_EN
        check("midrst_stats", {grant_cnt0, grant_cnt1, zero_cnt}, 0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_no_rsp", rsp_valid, 0);
        end
        @(posedge clk); #1;
        drive(1'b1, 1'b1, OP_AND, 4'b1100, 4'b1010);
        @(negedge clk);
        check("midrst_idle_ready1", req1_ready, 1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        wait_rsp(y, f, id);
        check("post_y", y, 4'b1000);
        check("post_flags", f, 4'b1000);
        check("post_id", id, 1);
`ifdef ALU_SHARE_STATS_EN
        check("stats_after", {grant_cnt0, grant_cnt1, zero_cnt}, {8'd0, 8'd1, 8'd0});
`endif
        repeat (2) @(negedge clk);
        check("final_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
